// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multi-cycle CPU control sequencer.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd8;
  localparam logic [3:0] OP_BEQ   = 4'd9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [2:0] ALU_ADD   = 3'd2;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd4;

  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic beq;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational one-hot classification of a 4-bit opcode.
module opcode_class
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: cls.rtype   = 1'b1;
      OP_LOAD:  cls.load    = 1'b1;
      OP_STORE: cls.store   = 1'b1;
      OP_BEQ:   cls.beq     = 1'b1;
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer issuing datapath strobes.
// Handshake: a memory request is held (mem_req with stable iord/mem_we) and completes in any cycle mem_ready=1.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        regdst,
  output logic        alusrc,
  output logic        regwrite,
  output logic        memreg,
  output logic [2:0]  aluop,
  output logic        retire,
  output logic [15:0] instr_count,
  output logic        trap,
  output logic [2:0]  state
);

  logic [2:0] state_q, state_d;
  logic [3:0] op_q;
  logic       trap_q;
  op_class_t  dec_cls;
  op_class_t  q_cls;
  logic       dec_legal;

  // dec_cls looks at the live IR in DECODE; q_cls drives the later phases.
  opcode_class u_dec_class (.opcode(opcode), .cls(dec_cls));
  opcode_class u_q_class   (.opcode(op_q),   .cls(q_cls));

  assign dec_legal = !dec_cls.illegal &&
                     (dec_cls.rtype || dec_cls.load || dec_cls.store || dec_cls.beq);

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    regdst    = 1'b0;
    alusrc    = 1'b0;
    regwrite  = 1'b0;
    memreg    = 1'b0;
    aluop     = 3'd0;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        aluop   = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alusrc = q_cls.load || q_cls.store;
        if (q_cls.rtype)     aluop = ALU_FUNCT;
        else if (q_cls.beq)  aluop = ALU_SUB;
        else                 aluop = ALU_ADD;
        if (q_cls.rtype) begin
          state_d = S_WB;
        end else if (q_cls.load || q_cls.store) begin
          state_d = S_MEM;
        end else if (q_cls.beq) begin
          pc_write = zero;
          pc_src   = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alusrc  = 1'b1;
        aluop   = ALU_ADD;
        mem_we  = q_cls.store;
        if (mem_ready) begin
          if (q_cls.load) begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        regdst   = q_cls.rtype;
        memreg   = q_cls.load;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 4'd0;
      trap_q      <= 1'b0;
      instr_count <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d == S_TRAP) trap_q <= 1'b1;
      if (retire) instr_count <= instr_count + 16'd1;
    end
  end

  assign trap  = trap_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: state sequences, strobes, latency, trap, counter wrap, reset.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_src, ir_write, mdr_write, mem_req, mem_we, iord;
  logic        regdst, alusrc, regwrite, memreg, retire, trap;
  logic [2:0]  aluop;
  logic [2:0]  state;
  logic [15:0] instr_count;
  logic [10:0] strobes;

  int checks = 0;
  int errors = 0;
  logic [15:0] cnt_model;
  logic [2:0]  exp_q[$];

  int n_pcw, n_irw, n_mdr, n_regw, n_we, n_iord, n_ret, cycles, mdr_idx;
  logic wb_regdst, wb_memreg, exec_pcw, exec_pcsrc, exec_alusrc;
  logic [2:0] exec_aluop;
  logic [2:0] ret_state;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mdr_write(mdr_write),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .regdst(regdst), .alusrc(alusrc),
    .regwrite(regwrite), .memreg(memreg), .aluop(aluop), .retire(retire),
    .instr_count(instr_count), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  assign strobes = {pc_write, pc_src, ir_write, mdr_write, mem_req, mem_we, iord,
                    regdst, alusrc, regwrite, memreg};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    opcode = 4'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_state", state, S_IDLE);
    check("rst_strobes", strobes, 0);
    check("rst_aluop", aluop, 0);
    check("rst_retire", retire, 0);
    check("rst_trap", trap, 0);
    check("rst_count", instr_count, 0);
    cnt_model = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_after_release", state, S_IDLE);
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at the negedge after retire.
  task automatic run_instr(input logic [3:0] op, input logic z, input int mstall);
    bit done;
    n_pcw = 0; n_irw = 0; n_mdr = 0; n_regw = 0; n_we = 0; n_iord = 0; n_ret = 0;
    mdr_idx = -1; cycles = 0; done = 0;
    wb_regdst = 1'b0; wb_memreg = 1'b0; exec_pcw = 1'b0; exec_pcsrc = 1'b0;
    exec_alusrc = 1'b0; exec_aluop = 3'd0; ret_state = 3'd7;
    opcode = op;
    zero = z;
    while (!done && cycles < 40) begin
      mem_ready = !(cycles >= 3 && cycles < 3 + mstall);
      #1;
      if (exp_q.size() != 0) check($sformatf("state[%0d]", cycles), state, exp_q.pop_front());
      n_pcw += int'(pc_write);
      n_irw += int'(ir_write);
      n_mdr += int'(mdr_write);
      n_regw += int'(regwrite);
      n_we += int'(mem_we);
      n_iord += int'(iord);
      n_ret += int'(retire);
      if (mdr_write) mdr_idx = cycles;
      if (state == S_WB) begin wb_regdst = regdst; wb_memreg = memreg; end
      if (state == S_EXEC) begin
        exec_pcw = pc_write; exec_pcsrc = pc_src;
        exec_alusrc = alusrc; exec_aluop = aluop;
      end
      if (retire) begin done = 1; ret_state = state; end
      cycles++;
      @(negedge clk);
    end
    if (!done) check("retire_timeout", 0, 1);
    exp_q.delete();
    mem_ready = 1'b1;
    #1;
    check("next_is_fetch", state, S_FETCH);
    cnt_model = cnt_model + 16'd1;
    check("instr_count", instr_count, cnt_model);
    check("retire_pulses", n_ret, 1);
    check("ir_write_pulses", n_irw, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    opcode = 4'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    cnt_model = 16'd0;
    #2;
    do_reset();

    // R-type
    exp_q = '{S_FETCH, S_DECODE, S_EXEC, S_WB};
    run_instr(OP_RTYPE, 1'b0, 0);
    check("r_cycles", cycles, 4);
    check("r_regwrite", n_regw, 1);
    check("r_regdst", wb_regdst, 1);
    check("r_memreg", wb_memreg, 0);
    check("r_aluop", exec_aluop, 4);
    check("r_alusrc", exec_alusrc, 0);
    check("r_pcw", n_pcw, 1);
    check("r_ret_state", ret_state, S_WB);

    // Load, two stall cycles in MEM
    exp_q = '{S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEM, S_MEM, S_WB};
    run_instr(OP_LOAD, 1'b0, 2);
    check("ld_cycles", cycles, 7);
    check("ld_mdr_pulses", n_mdr, 1);
    check("ld_mdr_idx", mdr_idx, 5);
    check("ld_memreg", wb_memreg, 1);
    check("ld_regdst", wb_regdst, 0);
    check("ld_iord_cycles", n_iord, 3);
    check("ld_we", n_we, 0);
    check("ld_alusrc", exec_alusrc, 1);
    check("ld_aluop", exec_aluop, 2);

    // Store
    exp_q = '{S_FETCH, S_DECODE, S_EXEC, S_MEM};
    run_instr(OP_STORE, 1'b0, 0);
    check("st_cycles", cycles, 4);
    check("st_we_cycles", n_we, 1);
    check("st_iord_cycles", n_iord, 1);
    check("st_regwrite", n_regw, 0);
    check("st_ret_state", ret_state, S_MEM);

    // beq taken then not taken
    exp_q = '{S_FETCH, S_DECODE, S_EXEC};
    run_instr(OP_BEQ, 1'b1, 0);
    check("beq1_cycles", cycles, 3);
    check("beq1_pcw", exec_pcw, 1);
    check("beq1_pcsrc", exec_pcsrc, 1);
    check("beq1_aluop", exec_aluop, 1);
    check("beq1_pcw_total", n_pcw, 2);
    exp_q = '{S_FETCH, S_DECODE, S_EXEC};
    run_instr(OP_BEQ, 1'b0, 0);
    check("beq0_cycles", cycles, 3);
    check("beq0_pcw", exec_pcw, 0);
    check("beq0_pcw_total", n_pcw, 1);
    check("beq0_regwrite", n_regw, 0);

    // Reset asserted while a load waits in MEM
    opcode = OP_LOAD;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i < 3);
      #1;
      if (i == 3) begin
        check("midmem_state", state, S_MEM);
        check("midmem_req", mem_req, 1);
      end
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midmem_rst_strobes", strobes, 0);
    check("midmem_rst_state", state, S_IDLE);
    check("midmem_rst_count", instr_count, 0);
    @(negedge clk);
    @(negedge clk);
    check("midmem_held_strobes", strobes, 0);
    rst_n = 1'b1;
    cnt_model = 16'd0;
    @(negedge clk);

    // Counter wrap
    force dut.instr_count = 16'hfffe;
    #1;
    release dut.instr_count;
    cnt_model = 16'hfffe;
    run_instr(OP_BEQ, 1'b0, 0);
    check("wrap_ffff", instr_count, 16'hffff);
    run_instr(OP_BEQ, 1'b1, 0);
    check("wrap_0000", instr_count, 16'h0000);

    // Illegal opcode
    opcode = 4'd5;
    mem_ready = 1'b1;
    #1;
    check("ill_fetch_state", state, S_FETCH);
    check("ill_fetch_req", mem_req, 1);
    check("ill_fetch_iord", iord, 0);
    check("ill_fetch_aluop", aluop, 2);
    @(negedge clk);
    #1;
    check("ill_decode_state", state, S_DECODE);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = i[0];
      zero = i[1];
      #1;
      check($sformatf("trap_state[%0d]", i), state, S_TRAP);
      check($sformatf("trap_flag[%0d]", i), trap, 1);
      check($sformatf("trap_strobes[%0d]", i), {retire, aluop, strobes}, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("trap_rst_flag", trap, 0);
    check("trap_rst_state", state, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("post_trap_fetch", state, S_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
